// File: rtl/sd_clk_pkg.sv
// Shared types for the SD card clock controller.
// Holds the FSM encoding and the power-up divider.
package sd_clk_pkg;

  typedef logic [7:0] div_t;

  localparam div_t INIT_DIV_DEFAULT = 8'd124;

  typedef enum logic [1:0] {
    STOPPED,
    RUN,
    DRAIN,
    LOAD
  } state_t;

endpackage

// File: rtl/sd_clock_ctrl_if.sv
// Host-side bundle of the SD clock controller.
// The host drives requests; the controller drives clock and status.
interface sd_clock_ctrl_if;
  import sd_clk_pkg::*;

  logic CLK_EN;
  logic BUSY;
  logic DIV_REQ;
  div_t DIV_IN;
  logic DIV_ACK;
  div_t DIV_CUR;
  logic SD_CLK;
  logic SD_CLK_RISE;
  logic SD_CLK_FALL;
  logic CLK_STOPPED;

  modport master (
    output CLK_EN, BUSY, DIV_REQ, DIV_IN,
    input  DIV_ACK, DIV_CUR, SD_CLK,
    input  SD_CLK_RISE, SD_CLK_FALL, CLK_STOPPED
  );

  modport slave (
    input  CLK_EN, BUSY, DIV_REQ, DIV_IN,
    output DIV_ACK, DIV_CUR, SD_CLK,
    output SD_CLK_RISE, SD_CLK_FALL, CLK_STOPPED
  );

endinterface

// File: rtl/sd_clk_div_core.sv
// Divider counter and SD_CLK toggle with registered edge strobes.
// suppress_rise lets the FSM park the clock low after a full low phase.
module sd_clk_div_core
  import sd_clk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic suppress_rise,
  input  div_t div,
  output logic sd_clk,
  output logic rise,
  output logic fall,
  output logic wrap_low
);

  div_t count;
  logic wrap;

  assign wrap     = (count == div);
  assign wrap_low = run && wrap && !sd_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      sd_clk <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!run) begin
        count  <= '0;
        sd_clk <= 1'b0;
      end else if (wrap) begin
        count <= '0;
        // a suppressed rise leaves the line low with no strobe
        if (!(suppress_rise && !sd_clk)) begin
          sd_clk <= ~sd_clk;
          rise   <= ~sd_clk;
          fall   <= sd_clk;
        end
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sd_clock_ctrl.sv
// SD card clock controller: run/stop and glitch-free divider change.
// Changes wait for BUSY low and a completed low phase before LOAD.
module sd_clock_ctrl
  import sd_clk_pkg::*;
#(
  parameter div_t INIT_DIV = INIT_DIV_DEFAULT
) (
  input logic           CLK,
  input logic           RST_N,
  sd_clock_ctrl_if.slave bus
);

  state_t state;
  div_t   div_cur;
  logic   ack;
  logic   stopped;
  logic   req_v;
  logic   run;
  logic   wrap_low;
  logic   sd;
  logic   rise;
  logic   fall;

  // the ack cycle masks a request the host has not yet dropped
  assign req_v = bus.DIV_REQ && !ack;
  assign run   = (state == RUN) || (state == DRAIN);

  sd_clk_div_core u_core (
    .clk           (CLK),
    .rst_n         (RST_N),
    .run           (run),
    .suppress_rise (state == DRAIN),
    .div           (div_cur),
    .sd_clk        (sd),
    .rise          (rise),
    .fall          (fall),
    .wrap_low      (wrap_low)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= STOPPED;
      div_cur <= INIT_DIV;
      ack     <= 1'b0;
      stopped <= 1'b1;
    end else begin
      ack <= 1'b0;
      unique case (state)
        STOPPED: begin
          if (req_v) begin
            state   <= LOAD;
            div_cur <= bus.DIV_IN;
            ack     <= 1'b1;
          end else if (bus.CLK_EN) begin
            state   <= RUN;
            stopped <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.CLK_EN || (req_v && !bus.BUSY)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wrap_low) begin
            stopped <= 1'b1;
            if (req_v) begin
              state   <= LOAD;
              div_cur <= bus.DIV_IN;
              ack     <= 1'b1;
            end else begin
              state <= STOPPED;
            end
          end
        end
        LOAD: begin
          if (bus.CLK_EN) begin
            state   <= RUN;
            stopped <= 1'b0;
          end else begin
            state <= STOPPED;
          end
        end
        default: begin
          state   <= STOPPED;
          stopped <= 1'b1;
        end
      endcase
    end
  end

  assign bus.DIV_ACK     = ack;
  assign bus.DIV_CUR     = div_cur;
  assign bus.SD_CLK      = sd;
  assign bus.SD_CLK_RISE = rise;
  assign bus.SD_CLK_FALL = fall;
  assign bus.CLK_STOPPED = stopped;

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// Directed and randomized bench for sd_clock_ctrl.
// A background monitor checks strobes, phase lengths and DIV_CUR.
module tb_sd_clock_ctrl;
  import sd_clk_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;

  sd_clock_ctrl_if bus ();

  sd_clock_ctrl dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int nd;
    int busy;
    int ack_lat;
    int first;
    int phase;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  int   errors    = 0;
  int   checks    = 0;
  int   ack_cnt   = 0;
  int   model_div = 124;
  logic prev_sd   = 1'b0;
  int   len       = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic wait_sd(input logic v, input int budget, output int n);
    n = 0;
    while (bus.SD_CLK !== v && n < budget) begin
      tick();
      n++;
    end
    if (bus.SD_CLK !== v) chk("sd_wait_timeout", n, -1);
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (bus.DIV_ACK !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (bus.DIV_ACK !== 1'b1) chk("ack_wait_timeout", n, -1);
  endtask

  // independent phase/strobe checker
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_sd   = 1'b0;
      len       = 0;
      model_div = 124;
    end else begin
      chk("strobes",
          int'({bus.SD_CLK_RISE, bus.SD_CLK_FALL}),
          int'({bus.SD_CLK & ~prev_sd, ~bus.SD_CLK & prev_sd}));
      if (bus.CLK_STOPPED)
        chk("stopped_strobe", int'(bus.SD_CLK_RISE | bus.SD_CLK_FALL), 0);
      if (bus.DIV_ACK) begin
        ack_cnt++;
        model_div = int'(bus.DIV_IN);
      end
      chk("div_cur", int'(bus.DIV_CUR), model_div);
      if (bus.SD_CLK !== prev_sd) begin
        if (prev_sd) begin
          chk("high_phase", len, model_div + 1);
        end else begin
          checks++;
          if (len < model_div + 1) begin
            errors++;
            $display("FAIL low_phase: got %0d cycles, expected >= %0d",
                     len, model_div + 1);
          end
        end
        len = 1;
      end else begin
        len++;
      end
      prev_sd = bus.SD_CLK;
    end
  end

  initial begin
    int n;
    int base;
    int bad;
    int exp_acks;
    int nreq;

    vecs[0] = '{nd: 3,   busy: 0,    ack_lat: 250, first: 5,   phase: 4};
    vecs[1] = '{nd: 0,   busy: 1000, ack_lat: 8,   first: 2,   phase: 1};
    vecs[2] = '{nd: 7,   busy: 0,    ack_lat: 2,   first: 9,   phase: 8};
    vecs[3] = '{nd: 1,   busy: 0,    ack_lat: 16,  first: 3,   phase: 2};
    vecs[4] = '{nd: 255, busy: 0,    ack_lat: 4,   first: 257, phase: 256};
    vecs[5] = '{nd: 3,   busy: 0,    ack_lat: 512, first: 5,   phase: 4};

    bus.CLK_EN  = 1'b0;
    bus.BUSY    = 1'b0;
    bus.DIV_REQ = 1'b0;
    bus.DIV_IN  = 8'd0;
    RST_N       = 1'b0;
    exp_acks    = 0;

    repeat (3) tick();
    chk("rst_sd",      int'(bus.SD_CLK), 0);
    chk("rst_rise",    int'(bus.SD_CLK_RISE), 0);
    chk("rst_fall",    int'(bus.SD_CLK_FALL), 0);
    chk("rst_ack",     int'(bus.DIV_ACK), 0);
    chk("rst_div",     int'(bus.DIV_CUR), 124);
    chk("rst_stopped", int'(bus.CLK_STOPPED), 1);
    #2 RST_N = 1'b1;
    tick();
    chk("idle_stopped", int'(bus.CLK_STOPPED), 1);

    bus.CLK_EN = 1'b1;
    wait_sd(1'b1, 400, n);
    chk("first_rise_124", n, 126);
    chk("run_stopped", int'(bus.CLK_STOPPED), 0);
    wait_sd(1'b0, 400, n);
    chk("high_124", n, 125);
    wait_sd(1'b1, 400, n);
    chk("low_124", n, 125);

    for (int i = 0; i < NV; i++) begin
      wait_sd(1'b0, 1200, n);
      wait_sd(1'b1, 1200, n);
      bus.DIV_IN  = 8'(vecs[i].nd);
      bus.DIV_REQ = 1'b1;
      bus.BUSY    = (vecs[i].busy > 0);
      if (vecs[i].busy > 0) begin
        base = ack_cnt;
        bad  = 0;
        repeat (vecs[i].busy) begin
          tick();
          if (bus.CLK_STOPPED) bad++;
        end
        chk("busy_no_ack", ack_cnt, base);
        chk("busy_running", bad, 0);
        wait_sd(1'b0, 1200, n);
        wait_sd(1'b1, 1200, n);
        bus.BUSY = 1'b0;
      end
      wait_ack(1200, n);
      chk("ack_lat", n, vecs[i].ack_lat);
      chk("ack_div", int'(bus.DIV_CUR), vecs[i].nd);
      chk("ack_stopped", int'(bus.CLK_STOPPED), 1);
      chk("ack_sd_low", int'(bus.SD_CLK), 0);
      bus.DIV_REQ = 1'b0;
      exp_acks++;
      wait_sd(1'b1, 1200, n);
      chk("first_rise", n, vecs[i].first);
      wait_sd(1'b0, 1200, n);
      chk("new_high", n, vecs[i].phase);
      wait_sd(1'b1, 1200, n);
      chk("new_low", n, vecs[i].phase);
      chk("ack_count", ack_cnt, exp_acks);
    end

    // stop while high: full high, full low, then parked low
    wait_sd(1'b0, 50, n);
    wait_sd(1'b1, 50, n);
    bus.CLK_EN = 1'b0;
    wait_sd(1'b0, 50, n);
    chk("stop_fall", n, 4);
    n = 0;
    while (!bus.CLK_STOPPED && n < 50) begin
      tick();
      n++;
    end
    chk("stop_lat", n, 4);
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.SD_CLK || !bus.CLK_STOPPED) bad++;
    end
    chk("held_stopped", bad, 0);

    // restart, then change with CLK_EN dropped during drain
    bus.CLK_EN = 1'b1;
    wait_sd(1'b1, 50, n);
    chk("restart_rise", n, 5);
    bus.DIV_IN  = 8'd2;
    bus.DIV_REQ = 1'b1;
    bus.CLK_EN  = 1'b0;
    wait_ack(50, n);
    chk("drain_load_lat", n, 8);
    chk("drain_load_stopped", int'(bus.CLK_STOPPED), 1);
    bus.DIV_REQ = 1'b0;
    exp_acks++;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.SD_CLK || !bus.CLK_STOPPED) bad++;
    end
    chk("load_then_stopped", bad, 0);
    chk("load_div", int'(bus.DIV_CUR), 2);
    chk("ack_count2", ack_cnt, exp_acks);

    // reset in the middle of a drain with a pending request
    bus.CLK_EN = 1'b1;
    wait_sd(1'b1, 50, n);
    chk("restart2_rise", n, 4);
    bus.DIV_IN  = 8'd9;
    bus.DIV_REQ = 1'b1;
    bus.CLK_EN  = 1'b0;
    tick();
    tick();
    chk("drain_still_high", int'(bus.SD_CLK), 1);
    base = ack_cnt;
    #2 RST_N = 1'b0;
    bus.DIV_REQ = 1'b0;
    tick();
    chk("mid_rst_sd",      int'(bus.SD_CLK), 0);
    chk("mid_rst_rise",    int'(bus.SD_CLK_RISE), 0);
    chk("mid_rst_fall",    int'(bus.SD_CLK_FALL), 0);
    chk("mid_rst_ack",     int'(bus.DIV_ACK), 0);
    chk("mid_rst_div",     int'(bus.DIV_CUR), 124);
    chk("mid_rst_stopped", int'(bus.CLK_STOPPED), 1);
    #2 RST_N = 1'b1;
    repeat (5) tick();
    chk("no_ack_after_rst", ack_cnt, base);
    chk("post_rst_stopped", int'(bus.CLK_STOPPED), 1);

    // random traffic; monitor checks phases throughout
    base = ack_cnt;
    nreq = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 49) == 0) bus.CLK_EN = ~bus.CLK_EN;
      if ($urandom_range(0, 29) == 0) bus.BUSY = ~bus.BUSY;
      if (bus.DIV_REQ && bus.DIV_ACK) begin
        bus.DIV_REQ = 1'b0;
      end else if (!bus.DIV_REQ && $urandom_range(0, 99) == 0) begin
        bus.DIV_IN  = 8'($urandom_range(0, 5));
        bus.DIV_REQ = 1'b1;
        nreq++;
      end
    end
    bus.BUSY = 1'b0;
    if (bus.DIV_REQ) begin
      wait_ack(2000, n);
      bus.DIV_REQ = 1'b0;
    end
    repeat (3) tick();
    chk("rand_acks", ack_cnt - base, nreq);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
